// File: rtl/dual_issue_scheduler.sv
// Dual-issue RV32I scheduler: pairs instructions from the fetch buffer and tracks pending load destinations.
// Optional issue statistics are enabled with the SCHED_PERF_CNT_EN macro.
module dual_issue_scheduler #(
    parameter int unsigned NREGS = 32
`ifdef SCHED_PERF_CNT_EN
    , parameter int unsigned PERF_W = 32
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              nothing_filled,
    input  logic [31:0]       instruction0,
    input  logic [31:0]       instruction1,
    input  logic              ex_ready,
    input  logic              wb_valid,
    input  logic [4:0]        wb_rd,
    output logic              freeze1,
    output logic              freeze2,
    output logic              dependency_on_ins2,
    output logic              issue0_valid,
    output logic [31:0]       issue0_instr,
    output logic              issue1_valid,
    output logic [31:0]       issue1_instr
`ifdef SCHED_PERF_CNT_EN
    , output logic [PERF_W-1:0] perf_dual
    , output logic [PERF_W-1:0] perf_single
    , output logic [PERF_W-1:0] perf_stall
`endif
);

    localparam int unsigned INSTR_W = 32;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;

    typedef enum logic [2:0] {
        DEC_IDLE,
        DEC_HOLD,
        DEC_BUBBLE,
        DEC_SINGLE,
        DEC_DUAL
    } dec_t;

    function automatic logic uses_rs1(input logic [6:0] op);
        return !(op == OP_LUI || op == OP_AUIPC || op == OP_JAL);
    endfunction

    function automatic logic uses_rs2(input logic [6:0] op);
        return (op == OP_RTYPE || op == OP_STORE || op == OP_BRANCH);
    endfunction

    function automatic logic writes_rd(input logic [6:0] op, input logic [4:0] rd);
        return !(op == OP_STORE || op == OP_BRANCH) && (rd != 5'd0);
    endfunction

    function automatic logic is_mem(input logic [6:0] op);
        return (op == OP_LOAD || op == OP_STORE);
    endfunction

    function automatic logic is_ctrl(input logic [6:0] op);
        return (op == OP_BRANCH || op == OP_JAL || op == OP_JALR);
    endfunction

    // Field extraction
    logic [6:0] op0, op1;
    logic [4:0] rd0, rd1, rs1_0, rs1_1, rs2_0, rs2_1;

    assign op0   = instruction0[6:0];
    assign rd0   = instruction0[11:7];
    assign rs1_0 = instruction0[19:15];
    assign rs2_0 = instruction0[24:20];
    assign op1   = instruction1[6:0];
    assign rd1   = instruction1[11:7];
    assign rs1_1 = instruction1[19:15];
    assign rs2_1 = instruction1[24:20];

    logic [NREGS-1:0] sb;
    logic [NREGS-1:0] sb_next;

    logic busy0, busy1, raw, waw, single_cond;
    dec_t dec;

    // Hazard detection against the scoreboard and between the pair
    always_comb begin
        busy0 = (uses_rs1(op0) && sb[rs1_0]) || (uses_rs2(op0) && sb[rs2_0]);
        busy1 = (uses_rs1(op1) && sb[rs1_1]) || (uses_rs2(op1) && sb[rs2_1]);
        raw   = writes_rd(op0, rd0) &&
                ((uses_rs1(op1) && (rs1_1 == rd0)) || (uses_rs2(op1) && (rs2_1 == rd0)));
        waw   = writes_rd(op0, rd0) && writes_rd(op1, rd1) && (rd0 == rd1);
        single_cond = (instruction1 == INSTR_W'(0)) || is_ctrl(op0) ||
                      (is_mem(op0) && is_mem(op1)) || raw || waw || busy1;
    end

    // Issue decision and fetch-buffer handshake, in priority order
    always_comb begin
        freeze1            = 1'b0;
        freeze2            = 1'b0;
        dependency_on_ins2 = 1'b0;
        dec                = DEC_IDLE;
        if (rst || nothing_filled) begin
            dec = DEC_IDLE;
        end else if (!ex_ready) begin
            freeze1 = 1'b1;
            freeze2 = 1'b1;
            dec     = DEC_HOLD;
        end else if (busy0) begin
            freeze1 = 1'b1;
            dec     = DEC_BUBBLE;
        end else if (single_cond) begin
            dependency_on_ins2 = 1'b1;
            dec                = DEC_SINGLE;
        end else begin
            dec = DEC_DUAL;
        end
    end

    // Issue slot registers
    always_ff @(posedge clk) begin
        if (rst) begin
            issue0_valid <= 1'b0;
            issue0_instr <= '0;
            issue1_valid <= 1'b0;
            issue1_instr <= '0;
        end else begin
            case (dec)
                DEC_HOLD: begin
                    issue0_valid <= issue0_valid;
                    issue0_instr <= issue0_instr;
                    issue1_valid <= issue1_valid;
                    issue1_instr <= issue1_instr;
                end
                DEC_SINGLE: begin
                    issue0_valid <= 1'b1;
                    issue0_instr <= instruction0;
                    issue1_valid <= 1'b0;
                    issue1_instr <= '0;
                end
                DEC_DUAL: begin
                    issue0_valid <= 1'b1;
                    issue0_instr <= instruction0;
                    issue1_valid <= 1'b1;
                    issue1_instr <= instruction1;
                end
                default: begin
                    issue0_valid <= 1'b0;
                    issue0_instr <= '0;
                    issue1_valid <= 1'b0;
                    issue1_instr <= '0;
                end
            endcase
        end
    end

    logic set0, set1;

    assign set0 = (dec == DEC_SINGLE || dec == DEC_DUAL) && (op0 == OP_LOAD) && (rd0 != 5'd0);
    assign set1 = (dec == DEC_DUAL) && (op1 == OP_LOAD) && (rd1 != 5'd0);

    // Writeback clear applied first so a same-cycle load issue wins
    always_comb begin
        sb_next = sb;
        if (wb_valid && (wb_rd != 5'd0)) begin
            sb_next[wb_rd] = 1'b0;
        end
        if (set0) begin
            sb_next[rd0] = 1'b1;
        end
        if (set1) begin
            sb_next[rd1] = 1'b1;
        end
        sb_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sb <= '0;
        end else begin
            sb <= sb_next;
        end
    end

`ifdef SCHED_PERF_CNT_EN
    // Saturating issue statistics
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_dual   <= '0;
            perf_single <= '0;
            perf_stall  <= '0;
        end else begin
            if (dec == DEC_DUAL && perf_dual != '1) begin
                perf_dual <= perf_dual + PERF_W'(1);
            end
            if (dec == DEC_SINGLE && perf_single != '1) begin
                perf_single <= perf_single + PERF_W'(1);
            end
            if (freeze1 && perf_stall != '1) begin
                perf_stall <= perf_stall + PERF_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_dual_issue_scheduler.sv
// Directed bench for dual_issue_scheduler: pairing rules, scoreboard, backpressure and reset.
module tb_dual_issue_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        nothing_filled;
    logic [31:0] instruction0;
    logic [31:0] instruction1;
    logic        ex_ready;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic        freeze1, freeze2, dependency_on_ins2;
    logic        issue0_valid, issue1_valid;
    logic [31:0] issue0_instr, issue1_instr;

    int n_checks = 0;
    int n_fail   = 0;

    dual_issue_scheduler dut (
        .clk                (clk),
        .rst                (rst),
        .nothing_filled     (nothing_filled),
        .instruction0       (instruction0),
        .instruction1       (instruction1),
        .ex_ready           (ex_ready),
        .wb_valid           (wb_valid),
        .wb_rd              (wb_rd),
        .freeze1            (freeze1),
        .freeze2            (freeze2),
        .dependency_on_ins2 (dependency_on_ins2),
        .issue0_valid       (issue0_valid),
        .issue0_instr       (issue0_instr),
        .issue1_valid       (issue1_valid),
        .issue1_instr       (issue1_instr)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] addi(input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
        return {imm, rs1, 3'b000, rd, 7'b0010011};
    endfunction

    function automatic logic [31:0] add(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        return {7'b0000000, rs2, rs1, 3'b000, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] sub(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        return {7'b0100000, rs2, rs1, 3'b000, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] lw(input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
        return {imm, rs1, 3'b010, rd, 7'b0000011};
    endfunction

    function automatic logic [31:0] sw(input logic [4:0] rs2, input logic [4:0] rs1, input logic [11:0] imm);
        return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
    endfunction

    function automatic logic [31:0] beq(input logic [4:0] rs1, input logic [4:0] rs2);
        return {7'b0000000, rs2, rs1, 3'b000, 5'b00000, 7'b1100011};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Flags packed as {freeze1, freeze2, dependency_on_ins2}
    task automatic chk_flags(input string tag, input logic [2:0] exp);
        chk(tag, 32'({freeze1, freeze2, dependency_on_ins2}), 32'(exp));
    endtask

    task automatic chk_slots(input string tag, input logic v0, input logic [31:0] i0,
                             input logic v1, input logic [31:0] i1);
        chk({tag, ".v0"}, 32'(issue0_valid), 32'(v0));
        chk({tag, ".i0"}, issue0_instr, i0);
        chk({tag, ".v1"}, 32'(issue1_valid), 32'(v1));
        chk({tag, ".i1"}, issue1_instr, i1);
    endtask

    task automatic present(input logic [31:0] i0, input logic [31:0] i1);
        instruction0 = i0;
        instruction1 = i1;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst            = 1'b1;
        nothing_filled = 1'b0;
        ex_ready       = 1'b0;
        wb_valid       = 1'b0;
        wb_rd          = 5'd0;
        present(addi(5'd1, 5'd0, 12'd1), addi(5'd2, 5'd0, 12'd2));
        chk_flags("rst_forces_flags", 3'b000);
        tick();
        chk_slots("reset", 1'b0, 32'd0, 1'b0, 32'd0);

        rst            = 1'b0;
        ex_ready       = 1'b1;
        nothing_filled = 1'b1;
        present(addi(5'd1, 5'd0, 12'd1), addi(5'd2, 5'd0, 12'd2));
        chk_flags("empty_flags", 3'b000);
        tick();
        chk_slots("empty", 1'b0, 32'd0, 1'b0, 32'd0);

        nothing_filled = 1'b0;
        present(addi(5'd1, 5'd0, 12'd1), addi(5'd2, 5'd0, 12'd2));
        chk_flags("dual_addi_flags", 3'b000);
        tick();
        chk_slots("dual_addi", 1'b1, addi(5'd1, 5'd0, 12'd1), 1'b1, addi(5'd2, 5'd0, 12'd2));

        present(add(5'd3, 5'd1, 5'd2), sub(5'd4, 5'd3, 5'd1));
        chk_flags("raw_flags", 3'b001);
        tick();
        chk_slots("raw", 1'b1, add(5'd3, 5'd1, 5'd2), 1'b0, 32'd0);

        present(lw(5'd5, 5'd0, 12'd0), addi(5'd8, 5'd0, 12'd3));
        chk_flags("lw_dual_flags", 3'b000);
        tick();
        chk_slots("lw_dual", 1'b1, lw(5'd5, 5'd0, 12'd0), 1'b1, addi(5'd8, 5'd0, 12'd3));

        present(add(5'd6, 5'd5, 5'd0), addi(5'd9, 5'd0, 12'd1));
        chk_flags("load_use_flags", 3'b100);
        tick();
        chk_slots("load_use", 1'b0, 32'd0, 1'b0, 32'd0);

        wb_valid = 1'b1;
        wb_rd    = 5'd5;
        present(add(5'd6, 5'd5, 5'd0), addi(5'd9, 5'd0, 12'd1));
        chk_flags("wb_no_bypass_flags", 3'b100);
        tick();
        chk_slots("wb_no_bypass", 1'b0, 32'd0, 1'b0, 32'd0);

        wb_valid = 1'b0;
        wb_rd    = 5'd0;
        present(add(5'd6, 5'd5, 5'd0), addi(5'd9, 5'd0, 12'd1));
        chk_flags("after_wb_flags", 3'b000);
        tick();
        chk_slots("after_wb", 1'b1, add(5'd6, 5'd5, 5'd0), 1'b1, addi(5'd9, 5'd0, 12'd1));

        present(lw(5'd10, 5'd1, 12'd0), sw(5'd2, 5'd1, 12'd4));
        chk_flags("mem_pair_flags", 3'b001);
        tick();
        chk_slots("mem_pair", 1'b1, lw(5'd10, 5'd1, 12'd0), 1'b0, 32'd0);

        present(beq(5'd1, 5'd2), addi(5'd11, 5'd0, 12'd1));
        chk_flags("branch_flags", 3'b001);
        tick();
        chk_slots("branch", 1'b1, beq(5'd1, 5'd2), 1'b0, 32'd0);

        present(addi(5'd12, 5'd0, 12'd1), 32'd0);
        chk_flags("ins1_empty_flags", 3'b001);
        tick();
        chk_slots("ins1_empty", 1'b1, addi(5'd12, 5'd0, 12'd1), 1'b0, 32'd0);

        present(addi(5'd13, 5'd0, 12'd1), add(5'd14, 5'd10, 5'd0));
        chk_flags("ins1_busy_flags", 3'b001);
        tick();
        chk_slots("ins1_busy", 1'b1, addi(5'd13, 5'd0, 12'd1), 1'b0, 32'd0);

        present(addi(5'd15, 5'd0, 12'd1), addi(5'd15, 5'd0, 12'd2));
        chk_flags("waw_flags", 3'b001);
        tick();
        chk_slots("waw", 1'b1, addi(5'd15, 5'd0, 12'd1), 1'b0, 32'd0);

        ex_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            present(addi(5'd16, 5'd0, 12'd1), addi(5'd17, 5'd0, 12'd2));
            chk_flags($sformatf("backpressure_flags_%0d", k), 3'b110);
            tick();
            chk_slots($sformatf("backpressure_%0d", k), 1'b1, addi(5'd15, 5'd0, 12'd1), 1'b0, 32'd0);
        end

        ex_ready = 1'b1;
        wb_valid = 1'b1;
        wb_rd    = 5'd7;
        present(lw(5'd7, 5'd0, 12'd8), 32'd0);
        chk_flags("set_wins_flags", 3'b001);
        tick();
        chk_slots("set_wins", 1'b1, lw(5'd7, 5'd0, 12'd8), 1'b0, 32'd0);

        wb_valid = 1'b0;
        wb_rd    = 5'd0;
        present(add(5'd16, 5'd7, 5'd0), 32'd0);
        chk_flags("x7_busy_flags", 3'b100);
        tick();
        chk_slots("x7_busy", 1'b0, 32'd0, 1'b0, 32'd0);

        rst = 1'b1;
        present(add(5'd16, 5'd7, 5'd0), 32'd0);
        chk_flags("rst_mid_stall_flags", 3'b000);
        tick();
        chk_slots("rst_mid_stall", 1'b0, 32'd0, 1'b0, 32'd0);

        rst = 1'b0;
        present(add(5'd16, 5'd7, 5'd0), 32'd0);
        chk_flags("post_rst_flags", 3'b001);
        tick();
        chk_slots("post_rst", 1'b1, add(5'd16, 5'd7, 5'd0), 1'b0, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
